// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-ported boot memory between
// the CPU port (0) and the debug loader port (1). All outputs are registered.
module bootrom_arbiter #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 16,
   parameter int ACC_CYCLES = 1,
   parameter int PROT_TOP   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0]      CNT_LOAD = 4'(ACC_CYCLES - 1);
   localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W+1)'(PROT_TOP);

   state_t              state, state_nxt;
   logic                gnt, gnt_nxt;
   logic                last, last_nxt;
   logic [3:0]          cnt, cnt_nxt;
   logic                cs_nxt, we_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   din_nxt, rdata_nxt;
   logic                ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;

   // Contest goes to the port not served last; a lone request wins outright.
   logic                sel, sel_we, refuse;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   always_comb begin
      sel       = (req0 && req1) ? ~last : req1;
      sel_we    = sel ? we1 : we0;
      sel_addr  = sel ? addr1 : addr0;
      sel_wdata = sel ? wdata1 : wdata0;
      refuse    = sel_we && ({1'b0, sel_addr} < PROT_LIM);
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      cnt_nxt   = cnt;
      cs_nxt    = mem_cs;
      we_nxt    = mem_we;
      addr_nxt  = mem_addr;
      din_nxt   = mem_din;
      rdata_nxt = rdata;
      ack0_nxt  = 1'b0;
      ack1_nxt  = 1'b0;
      err0_nxt  = 1'b0;
      err1_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               gnt_nxt = sel;
               if (refuse) begin
                  // Protected write: answer straight away, memory untouched.
                  state_nxt = RESP;
                  ack0_nxt  = ~sel;
                  ack1_nxt  = sel;
                  err0_nxt  = ~sel;
                  err1_nxt  = sel;
               end else begin
                  state_nxt = ACCESS;
                  cs_nxt    = 1'b1;
                  we_nxt    = sel_we;
                  addr_nxt  = sel_addr;
                  din_nxt   = sel_wdata;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               state_nxt = RESP;
               cs_nxt    = 1'b0;
               we_nxt    = 1'b0;
               if (!mem_we) rdata_nxt = mem_dout;
               ack0_nxt  = ~gnt;
               ack1_nxt  = gnt;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            last_nxt  = gnt;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 1'b0;
         last     <= 1'b1;
         cnt      <= 4'd0;
         mem_cs   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         rdata    <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         last     <= last_nxt;
         cnt      <= cnt_nxt;
         mem_cs   <= cs_nxt;
         mem_we   <= we_nxt;
         mem_addr <= addr_nxt;
         mem_din  <= din_nxt;
         rdata    <= rdata_nxt;
         ack0     <= ack0_nxt;
         ack1     <= ack1_nxt;
         err0     <= err0_nxt;
         err1     <= err1_nxt;
      end
   end

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Scoreboard bench for bootrom_arbiter: three instances cover the default
// build, ACC_CYCLES=3 and PROT_TOP=0, each with its own memory model.
module tb_bootrom_arbiter;

   localparam int N = 3;

   typedef struct {
      bit          port;
      bit          err;
      logic [15:0] rdata;
      int          lat;
   } exp_t;

   logic clk;
   logic tb_load;
   logic [N-1:0] rst, req0, req1, we0, we1, ack0, ack1, err0, err1, mem_cs, mem_we;
   logic [N-1:0][3:0]  addr0, addr1, mem_addr;
   logic [N-1:0][15:0] wdata0, wdata1, rdata, mem_din, mem_dout;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic [15:0] ref_mem [N][16];
   logic [15:0] last_rd [N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int i);
      return (i == 3) ? 16'h1007 : 16'hA000 + 16'(i);
   endfunction

   function automatic int acc_of(input int k);
      return (k == 1) ? 3 : 1;
   endfunction

   function automatic int prot_of(input int k);
      return (k == 2) ? 0 : 7;
   endfunction

   for (genvar k = 0; k < N; k++) begin : g_dut
      logic [15:0] mem [16];

      bootrom_arbiter #(.ACC_CYCLES(k == 1 ? 3 : 1), .PROT_TOP(k == 2 ? 0 : 7)) dut (
         .clk(clk), .rst(rst[k]),
         .req0(req0[k]), .req1(req1[k]), .we0(we0[k]), .we1(we1[k]),
         .addr0(addr0[k]), .addr1(addr1[k]), .wdata0(wdata0[k]), .wdata1(wdata1[k]),
         .ack0(ack0[k]), .ack1(ack1[k]), .err0(err0[k]), .err1(err1[k]),
         .rdata(rdata[k]), .mem_cs(mem_cs[k]), .mem_we(mem_we[k]),
         .mem_addr(mem_addr[k]), .mem_din(mem_din[k]), .mem_dout(mem_dout[k])
      );

      always @(posedge clk) begin
         if (tb_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
         end else if (mem_cs[k] && mem_we[k]) begin
            mem[mem_addr[k]] <= mem_din[k];
         end
      end
      assign mem_dout[k] = mem[mem_addr[k]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_ack(input int k, input int t);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
         return;
      end
      e = sb.pop_front();
      check("ack_both", {31'd0, ack0[k] & ack1[k]}, 0);
      check("ack_port", {31'd0, ack1[k]}, {31'd0, e.port});
      check("err", {31'd0, e.port ? err1[k] : err0[k]}, {31'd0, e.err});
      check("err_other", {31'd0, e.port ? err0[k] : err1[k]}, 0);
      check("rdata", {16'd0, rdata[k]}, {16'd0, e.rdata});
      check("latency", t, e.lat);
   endtask

   // One request from port p; drives, waits for ack with a cycle budget, then
   // leaves the DUT back in IDLE so the next call starts a fresh sample edge.
   task automatic txn(input int k, input bit p, input bit w, input logic [3:0] a,
                      input logic [15:0] d);
      exp_t e;
      bit   refused, got;
      int   cyc, cs_n;
      refused = w && (int'(a) < prot_of(k));
      e.port  = p;
      e.err   = refused;
      if (!w) last_rd[k] = ref_mem[k][a];
      else if (!refused) ref_mem[k][a] = d;
      e.rdata = last_rd[k];
      e.lat   = refused ? 1 : acc_of(k) + 1;
      sb.push_back(e);
      if (p) begin
         req1[k] = 1'b1; we1[k] = w; addr1[k] = a; wdata1[k] = d;
      end else begin
         req0[k] = 1'b1; we0[k] = w; addr0[k] = a; wdata0[k] = d;
      end
      cyc = 0; got = 0; cs_n = 0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (mem_cs[k]) begin
            cs_n++;
            check("mem_addr", {28'd0, mem_addr[k]}, {28'd0, a});
            check("mem_we", {31'd0, mem_we[k]}, {31'd0, w});
            if (w) check("mem_din", {16'd0, mem_din[k]}, {16'd0, d});
         end else begin
            check("we_no_cs", {31'd0, mem_we[k]}, 0);
         end
         if (ack0[k] || ack1[k]) begin
            got = 1;
            compare_ack(k, cyc);
            req0[k] = 1'b0;
            req1[k] = 1'b0;
         end
      end
      check("ack_seen", {31'd0, got}, 1);
      check("cs_cycles", cs_n, refused ? 0 : acc_of(k));
      @(negedge clk);
   endtask

   // Reset with both requests held, then both stay high: acks must alternate
   // starting with port 0, one every ACC_CYCLES+2 cycles.
   task automatic rr_test(input int k);
      int t, n_ack;
      rst[k] = 1'b1;
      req0[k] = 1'b1; we0[k] = 1'b0; addr0[k] = 4'd3;
      req1[k] = 1'b1; we1[k] = 1'b0; addr1[k] = 4'd5;
      repeat (2) @(negedge clk);
      check("rst_cs", {31'd0, mem_cs[k]}, 0);
      check("rst_ack", {30'd0, ack1[k], ack0[k]}, 0);
      check("rst_rdata", {16'd0, rdata[k]}, 0);
      last_rd[k] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.port  = i[0];
         e.err   = 1'b0;
         e.rdata = ref_mem[k][i[0] ? 5 : 3];
         e.lat   = acc_of(k) + 1 + i * (acc_of(k) + 2);
         sb.push_back(e);
      end
      last_rd[k] = ref_mem[k][5];
      rst[k] = 1'b0;
      t = 0; n_ack = 0;
      while (n_ack < 4 && t < 60) begin
         @(negedge clk);
         t++;
         if (ack0[k] || ack1[k]) begin
            n_ack++;
            compare_ack(k, t);
         end
      end
      check("rr_acks", n_ack, 4);
      req0[k] = 1'b0;
      req1[k] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      tb_load = 1'b1;
      rst = '1; req0 = '0; req1 = '0; we0 = '0; we1 = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int k = 0; k < N; k++) begin
         last_rd[k] = 16'h0000;
         for (int i = 0; i < 16; i++) ref_mem[k][i] = init_val(i);
      end
      repeat (3) @(negedge clk);
      tb_load = 1'b0;

      for (int k = 0; k < N; k++) rr_test(k);

      // default build: read, write/read-back, protection and its boundary
      txn(0, 0, 0, 4'd3, 16'h0000);
      txn(0, 1, 1, 4'd7, 16'hBEEF);
      txn(0, 0, 0, 4'd7, 16'h0000);
      txn(0, 0, 1, 4'd2, 16'h1234);
      txn(0, 1, 1, 4'd6, 16'h5555);
      txn(0, 1, 0, 4'd6, 16'h0000);
      txn(0, 0, 1, 4'd15, 16'hC0DE);
      txn(0, 1, 0, 4'd15, 16'h0000);

      // ACC_CYCLES=3: longer access window
      txn(1, 0, 0, 4'd3, 16'h0000);
      txn(1, 1, 1, 4'd9, 16'h5A5A);
      txn(1, 0, 0, 4'd9, 16'h0000);

      // reset in the second ACCESS cycle abandons the read
      req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 4'd9;
      @(negedge clk);
      check("mid_cs1", {31'd0, mem_cs[1]}, 1);
      @(negedge clk);
      check("mid_cs2", {31'd0, mem_cs[1]}, 1);
      rst[1] = 1'b1;
      req0[1] = 1'b0;
      @(negedge clk);
      check("mid_cs_off", {31'd0, mem_cs[1]}, 0);
      check("mid_no_ack", {30'd0, ack1[1], ack0[1]}, 0);
      rst[1] = 1'b0;
      last_rd[1] = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("mid_quiet", {30'd0, ack1[1], ack0[1]}, 0);
         check("mid_quiet_cs", {31'd0, mem_cs[1]}, 0);
      end
      check("mid_rdata", {16'd0, rdata[1]}, 0);
      txn(1, 0, 0, 4'd9, 16'h0000);

      // PROT_TOP=0: low-address write reaches the memory
      txn(2, 0, 1, 4'd2, 16'h1234);
      txn(2, 1, 0, 4'd2, 16'h0000);

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
